// File: rtl/ec_point_add.sv
// Affine EC point add/double over GF(P) with a shared bit-serial modular multiplier and a binary-Euclid inverse.
// Latency: 2 cycles for the identity cases, at most 6*DATA_WIDTH+12 otherwise; no backpressure, requests arriving while busy are dropped.
module ec_point_add #(
    parameter int                    DATA_WIDTH = 256,
    parameter logic [DATA_WIDTH-1:0] P          = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F,
    parameter logic [DATA_WIDTH-1:0] CURVE_A    = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] Px,
    input  logic [DATA_WIDTH-1:0] Py,
    input  logic [DATA_WIDTH-1:0] Qx,
    input  logic [DATA_WIDTH-1:0] Qy,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] Rx,
    output logic [DATA_WIDTH-1:0] Ry,
    output logic                  out_valid,
    output logic                  busy
);
    localparam int            W       = DATA_WIDTH;
    localparam int            CW      = $clog2(W);
    localparam logic [CW-1:0] CNT_TOP = CW'(W - 1);
    localparam logic [W-1:0]  ONE     = W'(1);

    typedef enum logic [3:0] {
        S_IDLE, S_CHK, S_NUM, S_INV, S_LAM, S_SQ, S_XR, S_YM, S_YR, S_DONE
    } state_t;

    function automatic logic [W-1:0] mod_add(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= {1'b0, P}) s = s - {1'b0, P};
        return s[W-1:0];
    endfunction

    // Modular wrap of the W-bit difference lands in [0,P) because the true result fits.
    function automatic logic [W-1:0] mod_sub(input logic [W-1:0] a, input logic [W-1:0] b);
        return (a >= b) ? (a - b) : (a - b + P);
    endfunction

    function automatic logic [W-1:0] mod_half(input logic [W-1:0] a);
        logic [W:0] s;
        s = a[0] ? ({1'b0, a} + {1'b0, P}) : {1'b0, a};
        return s[W:1];
    endfunction

    function automatic logic [W-1:0] mul_step(input logic [W-1:0] acc, input logic b_i,
                                              input logic [W-1:0] b);
        logic [W-1:0] t;
        t = mod_add(acc, acc);
        if (b_i) t = mod_add(t, b);
        return t;
    endfunction

    state_t         state, state_nxt;
    logic [W-1:0]   px, py, qx, qy;
    logic [W-1:0]   num, u, v, x1, x2, den_inv, lam, tmp, xr;
    logic           dbl;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   mul_acc;

    logic [W-1:0]   mul_a, mul_b, mul_nxt, ym_diff;
    logic           mul_on, mul_last;
    logic           p_inf, q_inf, x_eq, y_eq, early;

    assign p_inf    = (px == '0) && (py == '0);
    assign q_inf    = (qx == '0) && (qy == '0);
    assign x_eq     = (px == qx);
    assign y_eq     = (py == qy);
    assign early    = p_inf || q_inf || (x_eq && (!y_eq || (py == '0)));
    assign ym_diff  = mod_sub(px, xr);
    assign mul_last = (cnt == '0);
    assign mul_on   = ((state == S_NUM) && dbl) || (state == S_LAM) ||
                      (state == S_SQ) || (state == S_YM);

    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            S_NUM:   begin mul_a = px;      mul_b = px;      end
            S_LAM:   begin mul_a = num;     mul_b = den_inv; end
            S_SQ:    begin mul_a = lam;     mul_b = lam;     end
            S_YM:    begin mul_a = ym_diff; mul_b = lam;     end
            default: begin mul_a = '0;      mul_b = '0;      end
        endcase
    end

    assign mul_nxt = mul_step(mul_acc, mul_a[cnt], mul_b);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (in_valid) state_nxt = S_CHK;
            S_CHK:   state_nxt = early ? S_DONE : S_NUM;
            S_NUM:   if (!dbl || mul_last) state_nxt = S_INV;
            S_INV:   if ((u == ONE) || (v == ONE)) state_nxt = S_LAM;
            S_LAM:   if (mul_last) state_nxt = S_SQ;
            S_SQ:    if (mul_last) state_nxt = S_XR;
            S_XR:    state_nxt = S_YM;
            S_YM:    if (mul_last) state_nxt = S_YR;
            S_YR:    state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    assign out_valid = (state == S_DONE);
    assign busy      = (state != S_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px      <= '0;
            py      <= '0;
            qx      <= '0;
            qy      <= '0;
            num     <= '0;
            u       <= '0;
            v       <= '0;
            x1      <= '0;
            x2      <= '0;
            den_inv <= '0;
            lam     <= '0;
            tmp     <= '0;
            xr      <= '0;
            dbl     <= 1'b0;
            cnt     <= CNT_TOP;
            mul_acc <= '0;
            Rx      <= '0;
            Ry      <= '0;
        end else begin
            if (mul_on) begin
                if (mul_last) begin
                    mul_acc <= '0;
                    cnt     <= CNT_TOP;
                end else begin
                    mul_acc <= mul_nxt;
                    cnt     <= cnt - 1'b1;
                end
            end

            case (state)
                S_IDLE: if (in_valid) begin
                    px <= Px;
                    py <= Py;
                    qx <= Qx;
                    qy <= Qy;
                end
                S_CHK: begin
                    // Past the early-out checks, equal x means equal, nonzero y: a doubling.
                    dbl <= x_eq;
                    if (p_inf) begin
                        Rx <= qx;
                        Ry <= qy;
                    end else if (q_inf) begin
                        Rx <= px;
                        Ry <= py;
                    end else if (early) begin
                        Rx <= '0;
                        Ry <= '0;
                    end
                end
                S_NUM: begin
                    v  <= P;
                    x1 <= ONE;
                    x2 <= '0;
                    if (!dbl) begin
                        num <= mod_sub(qy, py);
                        u   <= mod_sub(qx, px);
                    end else if (mul_last) begin
                        num <= mod_add(mod_add(mod_add(mul_nxt, mul_nxt), mul_nxt), CURVE_A);
                        u   <= mod_add(py, py);
                    end
                end
                S_INV: begin
                    // Invariant: x1*den == u and x2*den == v (mod P); subtract and halve in one step.
                    if (u == ONE) begin
                        den_inv <= x1;
                    end else if (v == ONE) begin
                        den_inv <= x2;
                    end else if (!u[0]) begin
                        u  <= u >> 1;
                        x1 <= mod_half(x1);
                    end else if (!v[0]) begin
                        v  <= v >> 1;
                        x2 <= mod_half(x2);
                    end else if (u >= v) begin
                        u  <= (u - v) >> 1;
                        x1 <= mod_half(mod_sub(x1, x2));
                    end else begin
                        v  <= (v - u) >> 1;
                        x2 <= mod_half(mod_sub(x2, x1));
                    end
                end
                S_LAM: if (mul_last) lam <= mul_nxt;
                S_SQ:  if (mul_last) tmp <= mul_nxt;
                S_XR:  xr <= mod_sub(mod_sub(tmp, px), qx);
                S_YM:  if (mul_last) tmp <= mul_nxt;
                S_YR: begin
                    Rx <= xr;
                    Ry <= mod_sub(tmp, py);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ec_point_add.sv
// Bench for ec_point_add on the toy curve y^2 = x^3 + 2x + 2 over GF(17), generator G=(5,1) of order 19.
module tb_ec_point_add;
    localparam int W       = 8;
    localparam int MAX_LAT = 6 * W + 12;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] Px = '0, Py = '0, Qx = '0, Qy = '0;
    logic         in_valid = 1'b0;
    logic [W-1:0] Rx, Ry;
    logic         out_valid, busy;

    ec_point_add #(.DATA_WIDTH(W), .P(8'd17), .CURVE_A(8'd2)) dut (
        .clk(clk), .rst_n(rst_n),
        .Px(Px), .Py(Py), .Qx(Qx), .Qy(Qy),
        .in_valid(in_valid),
        .Rx(Rx), .Ry(Ry),
        .out_valid(out_valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int x;
        int y;
        int t0;
        int lat;
        int tag;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   total = 0;
    int   bad   = 0;
    int   tag_n = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    // Monitor: every out_valid must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (out_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_out_valid: got out_valid=1 at cycle %0d, required no pending request", cyc);
            end else begin
                e = sb.pop_front();
                total++;
                if (Rx !== W'(e.x) || Ry !== W'(e.y)) begin
                    bad++;
                    $display("FAIL result#%0d: got R=(%0d,%0d), required (%0d,%0d)", e.tag, Rx, Ry, e.x, e.y);
                end
                total++;
                if (e.lat > 0) begin
                    if (cyc - e.t0 != e.lat) begin
                        bad++;
                        $display("FAIL latency#%0d: got %0d cycles, required %0d", e.tag, cyc - e.t0, e.lat);
                    end
                end else if (cyc - e.t0 > MAX_LAT) begin
                    bad++;
                    $display("FAIL latency#%0d: got %0d cycles, required <= %0d", e.tag, cyc - e.t0, MAX_LAT);
                end
            end
        end
    end

    function automatic int minv(input int d);
        for (int i = 1; i < 17; i++)
            if ((d * i) % 17 == 1) return i;
        return 0;
    endfunction

    function automatic void model_add(input int px, input int py, input int qx, input int qy,
                                      output int rx, output int ry);
        int n, d, lam;
        rx = 0;
        ry = 0;
        if (px == 0 && py == 0) begin rx = qx; ry = qy; return; end
        if (qx == 0 && qy == 0) begin rx = px; ry = py; return; end
        if (px == qx && (py != qy || py == 0)) return;
        if (px == qx) begin
            n = (3 * px * px + 2) % 17;
            d = (2 * py) % 17;
        end else begin
            n = (qy - py + 17) % 17;
            d = (qx - px + 17) % 17;
        end
        lam = (n * minv(d)) % 17;
        rx  = (lam * lam - px - qx + 34) % 17;
        ry  = (lam * ((px - rx + 17) % 17) - py + 17) % 17;
    endfunction

    task automatic issue(input int px, input int py, input int qx, input int qy,
                         input bit push, input int ex, input int ey, input int lat);
        exp_t n;
        @(negedge clk);
        Px = W'(px);
        Py = W'(py);
        Qx = W'(qx);
        Qy = W'(qy);
        in_valid = 1'b1;
        if (push) begin
            n.x = ex; n.y = ey; n.t0 = cyc; n.lat = lat; n.tag = tag_n;
            sb.push_back(n);
        end
        tag_n++;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < MAX_LAT + 40; i++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1'b1;
                break;
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got no out_valid, required one within %0d cycles", name, MAX_LAT + 40);
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int ax, ay, nx, ny, dx, dy;

        @(negedge clk);
        check("reset_rx", Rx, 0);
        check("reset_ry", Ry, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;

        issue(5, 1, 6, 3, 1, 10, 6, 0);
        wait_done("add");
        issue(5, 1, 5, 1, 1, 6, 3, 0);
        wait_done("double");
        check("inv_of_2", dut.den_inv, 9);

        issue(0, 0, 6, 3, 1, 6, 3, 2);
        wait_done("p_inf");
        issue(6, 3, 0, 0, 1, 6, 3, 2);
        wait_done("q_inf");
        issue(5, 1, 5, 16, 1, 0, 0, 2);
        wait_done("negation");

        // A second pulse mid-operation must vanish without a trace.
        issue(6, 3, 5, 1, 1, 10, 6, 0);
        @(negedge clk);
        Px = 8'd0; Py = 8'd0; Qx = 8'd1; Qy = 8'd1;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        wait_done("busy_ignore");
        repeat (MAX_LAT) @(negedge clk);

        // Abort in the inverse phase (den=5 takes several Euclid steps).
        issue(5, 1, 10, 6, 0, 0, 0, 0);
        repeat (3) @(negedge clk);
        check("abort_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_rx", Rx, 0);
        check("abort_ry", Ry, 0);
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        issue(5, 1, 10, 6, 1, 3, 1, 0);
        wait_done("after_abort");

        ax = 0;
        ay = 0;
        for (int k = 1; k <= 19; k++) begin
            model_add(ax, ay, 5, 1, nx, ny);
            issue(ax, ay, 5, 1, 1, nx, ny, 0);
            wait_done("ladder_add");
            ax = nx;
            ay = ny;
            model_add(ax, ay, ax, ay, dx, dy);
            issue(ax, ay, ax, ay, 1, dx, dy, 0);
            wait_done("ladder_dbl");
        end

        repeat (5) @(negedge clk);
        check("scoreboard_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
